// File: rtl/alu_md_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package alu_md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic int unsigned md_cnt_w(input int unsigned xlen, input int unsigned bpc);
    return $clog2(xlen / bpc + 1);
  endfunction

endpackage

// File: rtl/md_step.sv
// One CALC iteration: BPC shift-add multiply steps or BPC restoring-divide steps.
module md_step #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 1
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_sum;

  // acc = {partial hi, multiplier/dividend lo}; mul shifts right, div shifts left
  always_comb begin
    w_acc = i_acc;
    w_sum = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      if (i_div) begin
        w_sum = w_acc[2*XLEN-1:XLEN-1];
        if (w_sum >= {1'b0, i_opnd}) begin
          w_sum = w_sum - {1'b0, i_opnd};
          w_acc = {w_sum[XLEN-1:0], w_acc[XLEN-2:0], 1'b1};
        end else begin
          w_acc = {w_sum[XLEN-1:0], w_acc[XLEN-2:0], 1'b0};
        end
      end else begin
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, i_opnd} : '0);
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request and result handshakes.
module alu_muldiv
  import alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_md_data
);

  localparam int unsigned STEPS = XLEN / BPC;
  localparam int unsigned CNT_W = md_cnt_w(XLEN, BPC);

  md_state_e         r_state, w_state_nxt;
  md_op_e            r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_neg;
  logic [XLEN-1:0]   r_data;

  md_op_e            w_op;
  logic              w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf, w_special, w_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic [2*XLEN-1:0] w_step, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_result;
  logic              w_last;

  assign o_ready  = (r_state == IDLE);
  assign o_valid  = (r_state == DONE);
  assign o_md_data = r_data;

  assign w_op     = md_op_e'(i_md_op);
  assign w_accept = i_valid & o_ready & ~i_flush;
  assign w_is_div = i_md_op[2];
  assign w_a_sgn  = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
  assign w_b_sgn  = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
  assign w_a_neg  = w_a_sgn & i_operand_a[XLEN-1];
  assign w_b_neg  = w_b_sgn & i_operand_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_operand_a : i_operand_a;
  assign w_b_mag  = w_b_neg ? -i_operand_b : i_operand_b;
  // remainder follows the dividend sign; everything else follows the sign product
  assign w_neg    = (w_is_div && i_md_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0    = w_is_div & (i_operand_b == '0);
  assign w_ovf     = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                     (i_operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_operand_b == '1);
  assign w_special = w_div0 | w_ovf;
  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = i_md_op[1] ? i_operand_a : '1;
    else        w_special_res = i_md_op[1] ? '0 : i_operand_a;
  end

  md_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (r_op[2]),
    .o_acc  (w_step)
  );

  // fix-up runs on the final step's output so DONE is entered on the last CALC edge
  assign w_prod = r_neg ? -w_step : w_step;
  assign w_quo  = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
  assign w_rem  = r_neg ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
  always_comb begin
    w_result = '0;
    case (r_op)
      MD_MUL:                     w_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            w_result = w_quo;
      default:                    w_result = w_rem;
    endcase
  end

  assign w_last = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (i_flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op   <= MD_MUL;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
      r_neg  <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= w_op;
      r_cnt  <= CNT_W'(STEPS);
      r_acc  <= {{XLEN{1'b0}}, w_a_mag};
      r_opnd <= w_b_mag;
      r_neg  <= w_neg;
      if (w_special) r_data <= w_special_res;
    end else if (r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last && !i_flush) r_data <= w_result;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: result table plus handshake, backpressure and abort sequences.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, o_ready, o_valid, i_ready;
  logic [2:0]  op;
  logic [31:0] a, b, data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32), .BPC(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .i_md_op     (op),
    .i_operand_a (a),
    .i_operand_b (b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_md_data   (data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request; returns after the accept edge (+1) with operands scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    valid = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Edges counted inclusive of the accept edge until o_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
  endtask

  initial begin
    int lat, seen;
    string nm;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b100, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'h1234,     32'd0,        32'h1234,     1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 33};
    vecs[13] = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33};
    vecs[14] = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'd2,        33};
    vecs[15] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[16] = '{3'b001, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[17] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};

    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; i_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("reset_valid", {31'b0, o_valid}, 32'd0);
    check("reset_ready", {31'b0, o_ready}, 32'd1);
    check("reset_data", data, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      nm = $sformatf("vec%0d", i);
      check({nm, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({nm, "_data"}, data, vecs[i].exp);
      @(posedge clk); #1;
      check({nm, "_ready_after"}, {31'b0, o_ready}, 32'd1);
    end

    // backpressure: result held while i_ready is low
    i_ready = 1'b0;
    issue(3'b000, 32'd7, 32'd3);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd33);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid_hold", {31'b0, o_valid}, 32'd1);
      check("bp_data_hold", data, 32'd21);
      check("bp_ready_low", {31'b0, o_ready}, 32'd0);
    end
    @(negedge clk) i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'b0, o_valid}, 32'd0);
    check("bp_release_ready", {31'b0, o_ready}, 32'd1);
    check("bp_data_kept", data, 32'd21);
    issue(3'b101, 32'd100, 32'd7);
    check("b2b_accepted", {31'b0, o_ready}, 32'd0);
    wait_valid(lat);
    check("b2b_lat", 32'(lat), 32'd33);
    check("b2b_data", data, 32'd14);
    @(posedge clk); #1;

    // flush on the 10th CALC cycle
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'b0, o_ready}, 32'd1);
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    count_valid(40, seen);
    check("flush_no_result", 32'(seen), 32'd0);

    // reset on the 10th CALC cycle
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_data", data, 32'd0);
    count_valid(40, seen);
    check("rst_no_result", 32'(seen), 32'd0);

    // request with simultaneous flush is dropped
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("vf_ready", {31'b0, o_ready}, 32'd1);
    count_valid(40, seen);
    check("vf_no_result", 32'(seen), 32'd0);

    // flush in DONE discards the pending result
    i_ready = 1'b0;
    issue(3'b100, 32'd9, 32'd0);
    check("done_flush_pre", {31'b0, o_valid}, 32'd1);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_valid", {31'b0, o_valid}, 32'd0);
    check("done_flush_ready", {31'b0, o_ready}, 32'd1);
    i_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit implementing the RV32M operations, parametrised in data width and bits retired per cycle.
- Sits in the EX stage beside the combinational ALU and handles ops that the ALU cannot complete in one cycle.
- Operation request and result each use valid/ready handshakes. The pipeline stalls on o_ready and can kill an in-flight op with i_flush.

Parameters:
- XLEN, 32, operand and result width; must be even and ≥ 8.
- BPC, 1, quotient/product bits resolved per CALC cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  kill in-flight or pending op.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_md_op  in  3  op, encoded as RV funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- i_operand_a  in  XLEN  rs1 value.
- i_operand_b  in  XLEN  rs2 value.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_md_data  out  XLEN  result.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state ← IDLE; o_valid=0; o_md_data=0; o_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts silently; no result is produced.
- States: IDLE, CALC, DONE.
  - o_ready = (state==IDLE).
  - o_valid = (state==DONE).
- Accept: an edge where i_valid & o_ready & ~i_flush.
  - Capture the op, both operands, and the sign flags.
  - Signed operands are converted to magnitudes. MULHSU treats only a as signed; MULHU, DIVU, REMU treat both as unsigned.
- Special cases, decided at accept time; next state DONE, so o_valid is high 1 edge after accept:
  - Division by zero: DIV/DIVU → all ones; REM/REMU → operand_a.
  - Signed overflow (DIV/REM with a = 1<<(XLEN-1), b = all ones): DIV → a; REM → 0.
- Normal path: next state CALC, with counter = XLEN/BPC.
  - Multiply: shift-add over 2·XLEN-bit magnitude product, BPC multiplier bits per cycle.
  - Divide: restoring division, BPC quotient bits per cycle.
  - Counter decrements each CALC cycle. When it reaches 0, the next state is DONE.
  - Sign fix-up (two's-complement negate) is applied combinationally on the CALC→DONE edge and registered into o_md_data.
  - Result: o_valid high exactly XLEN/BPC+1 edges after the accept edge (33 at default).
- Result selection:
  - MUL → product[XLEN-1:0]; MULH/MULHSU/MULHU → product[2XLEN-1:XLEN].
  - DIV/DIVU → quotient; REM/REMU → remainder.
  - Signs: quotient negative iff signs differ; remainder takes the sign of the dividend.
- DONE: o_valid and o_md_data are held stable until i_valid... correction: until i_ready=1.
  - On the handshake edge, state ← IDLE and o_valid ← 0. o_md_data keeps its last value.
  - No bypass: a new request can be accepted no earlier than the cycle after the result handshake (o_ready low in DONE).
- i_flush (synchronous):
  - In any state, the next state is IDLE and o_valid ← 0; any result is discarded.
  - i_flush overrides a simultaneous accept (request dropped) and a simultaneous result handshake.
- Reset has priority over flush.
- Operands and op on the inputs are don't-care outside the accept edge; the unit never re-samples them.
- No X propagation: all datapath registers are reset.

Decomposition:
- Package alu_md_pkg:
  - md_op_e enum (8 encodings above), md_state_e enum (IDLE/CALC/DONE).
  - Helper constant for counter width: $clog2(XLEN/BPC+1).
- One sub-module, md_step: purely combinational single-iteration datapath.
  - Takes partial product/remainder, operand magnitude, mode (mul/div).
  - Emits next partial state for BPC bits.
  - Instantiated once; the top holds the FSM, counter, fix-up and handshakes.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (−3), i_ready=1 → o_md_data=0xFFFFFFEB, o_valid rises 33 edges after accept, o_ready returns 1 the following cycle.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIV 0x1234/0 → 0xFFFFFFFF and REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; each with o_valid 1 edge after accept.
5. Backpressure: hold i_ready=0 for 5 cycles in DONE → o_valid and o_md_data stable, o_ready=0; raise i_ready → IDLE next edge; a back-to-back request is accepted the following cycle.
6. Abort cases:
   - Assert i_flush on the 10th CALC cycle of a DIVU → o_valid never rises, o_ready=1 next cycle.
   - Repeat the op with i_rst_n=0 → same abort behaviour.
   - i_valid & i_flush on the same edge → not accepted.
